// File: rtl/id00001001_host_loader.sv
// Host-side loader for the ID00001001 controller: takes host CONF/DATA/START/CLEAR
// commands, fills MEMI, pulses start, and watches busy/done to raise a sticky interrupt.
module id00001001_host_loader #(
  parameter int ADDR_WIDTH_MEMI = 6,
  parameter int SIZE_CR         = 1,
  parameter int BUSY_TIMEOUT    = 16
) (
  input  logic                       clk,
  input  logic                       rst_a,
  input  logic                       en_s,
  input  logic                       h_valid,
  output logic                       h_ready,
  input  logic [1:0]                 h_cmd,
  input  logic [31:0]                h_data,
  output logic [ADDR_WIDTH_MEMI-1:0] memi_addr,
  output logic [31:0]                memi_data,
  output logic                       memi_we,
  output logic [SIZE_CR*32-1:0]      confReg,
  output logic                       start,
  input  logic                       busy_f,
  input  logic                       done_f,
  output logic                       stat_done,
  output logic                       stat_err,
  output logic                       stat_full,
  output logic                       irq
);

  localparam int CI_W = (SIZE_CR > 1) ? $clog2(SIZE_CR) : 1;
  localparam int TW   = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_DATA  = 2'd1;
  localparam logic [1:0] CMD_START = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_RUN} state_t;

  state_t                     r_state;
  logic [ADDR_WIDTH_MEMI-1:0] r_wp;
  logic [ADDR_WIDTH_MEMI-1:0] r_addr;
  logic [31:0]                r_wdata;
  logic                       r_we_pend;
  logic [CI_W-1:0]            r_ci;
  logic [SIZE_CR-1:0][31:0]   r_conf;
  logic [TW-1:0]              r_tmo;
  logic                       r_done;
  logic                       r_err;
  logic                       r_full;
  logic                       w_xfer;
  logic                       w_complete;

  assign h_ready    = en_s & (r_state == S_IDLE);
  assign w_xfer     = h_valid & h_ready;
  // a done pulse ends the run even if busy_f was never observed
  assign w_complete = done_f & ((r_state == S_WAIT_BUSY) | (r_state == S_RUN));

  // strobes are held registered while en_s is low and released on its return
  assign memi_we   = r_we_pend & en_s;
  assign start     = en_s & (r_state == S_START);
  assign memi_addr = r_addr;
  assign memi_data = r_wdata;
  assign confReg   = r_conf;
  assign stat_done = r_done;
  assign stat_err  = r_err;
  assign stat_full = r_full;
  assign irq       = r_done | r_err;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state   <= S_IDLE;
      r_wp      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we_pend <= 1'b0;
      r_ci      <= '0;
      r_conf    <= '0;
      r_tmo     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_full    <= 1'b0;
    end else if (en_s) begin
      r_we_pend <= 1'b0;
      if (w_complete) begin
        r_done  <= 1'b1;
        r_wp    <= '0;
        r_full  <= 1'b0;
        r_ci    <= '0;
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_xfer) begin
              case (h_cmd)
                CMD_CONF: begin
                  for (int k = 0; k < SIZE_CR; k++)
                    if (r_ci == CI_W'(k)) r_conf[k] <= h_data;
                  r_ci <= (r_ci == CI_W'(SIZE_CR - 1)) ? '0 : r_ci + 1'b1;
                end
                CMD_DATA: begin
                  if (r_full) begin
                    r_err <= 1'b1;
                  end else begin
                    r_we_pend <= 1'b1;
                    r_addr    <= r_wp;
                    r_wdata   <= h_data;
                    r_wp      <= r_wp + 1'b1;
                    if (r_wp == '1) r_full <= 1'b1;
                  end
                end
                CMD_START: r_state <= S_START;
                default: begin
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
                  r_wp   <= '0;
                  r_ci   <= '0;
                  r_full <= 1'b0;
                end
              endcase
            end
          end
          S_START: begin
            r_state <= S_WAIT_BUSY;
            r_tmo   <= '0;
          end
          S_WAIT_BUSY: begin
            // counter starts one cycle after the pulse, so the limit is offset by
            // two to flag the error exactly BUSY_TIMEOUT cycles after start
            if (busy_f) begin
              r_state <= S_RUN;
            end else if (r_tmo == TW'(BUSY_TIMEOUT - 2)) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
